// File: rtl/net_seq_pkg.sv
// Shared definitions for network sequencers: state encoding and
// layer-index width helper.
package net_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_START,
        S_RUN,
        S_LATCH
    } seq_state_e;

    // Width of a layer index; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// Suitable for any slow asynchronous level (sample clocks, jack/gate inputs).
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    // Next-state: shift the level through the synchroniser and flag a 0->1 step.
    always_comb begin
        meta_d  = din;
        sync_d  = meta_q;
        prev_d  = sync_q;
        pulse_d = sync_q & ~prev_q;
    end

    // Register stage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/layer_sequencer.sv
// Runs one inference pass per sample edge: shift the input buffer, then
// reset and await each conv layer in turn, then strobe the output latch.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a sample tick
// S_SHIFT | advancing the left-shift buffer, layer index cleared
// S_START | one-cycle reset pulse to layer k, timeout counter cleared
// S_RUN   | waiting for layer k done (first cycle ignored: stale out_v)
// S_LATCH | output-latch strobe for the last layer
module layer_sequencer
    import net_seq_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sample_clk,
    input  logic [NUM_LAYERS-1:0]               layer_done,
    input  logic                                clr_err,
    output logic                                lsb_shift,
    output logic [NUM_LAYERS-1:0]               layer_rst,
    output logic [sel_width(NUM_LAYERS)-1:0]    layer_sel,
    output logic                                out_latch,
    output logic                                busy,
    output logic                                overrun,
    output logic                                timeout_err
);

    localparam int SW = sel_width(NUM_LAYERS);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0]         LAST_K   = SW'(NUM_LAYERS - 1);
    localparam logic [CW-1:0]         CNT_MAX  = CW'(TIMEOUT);
    localparam logic [NUM_LAYERS-1:0] ONE_HOT0 = NUM_LAYERS'(1);

    seq_state_e             state_q, state_d;
    logic [SW-1:0]          k_q, k_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   first_q, first_d;
    logic                   lsb_q, lsb_d;
    logic [NUM_LAYERS-1:0]  lrst_q, lrst_d;
    logic [SW-1:0]          sel_q, sel_d;
    logic                   latch_q, latch_d;
    logic                   busy_q, busy_d;
    logic                   ovr_q, ovr_d;
    logic                   to_q, to_d;
    logic                   tick;
    logic                   ovr_set, to_set;

    sync_edge_detect u_sample_edge (
        .clk   (clk),
        .rst   (rst),
        .din   (sample_clk),
        .pulse (tick)
    );

    // Next-state and registered-output decode; a tick outside IDLE always restarts the pass.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        first_d = 1'b0;
        ovr_set = 1'b0;
        to_set  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tick) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                k_d     = '0;
                state_d = S_START;
            end
            S_START: begin
                cnt_d   = '0;
                first_d = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!first_q) begin
                    if (layer_done[k_q]) begin
                        if (k_q == LAST_K) begin
                            state_d = S_LATCH;
                        end else begin
                            k_d     = k_q + SW'(1);
                            state_d = S_START;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        to_set  = 1'b1;
                        state_d = S_IDLE;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_LATCH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tick && (state_q != S_IDLE)) begin
            state_d = S_SHIFT;
            ovr_set = 1'b1;
            to_set  = 1'b0;
        end

        lsb_d   = (state_d == S_SHIFT);
        lrst_d  = (state_d == S_START) ? (ONE_HOT0 << k_d) : '0;
        sel_d   = ((state_d == S_START) || (state_d == S_RUN)) ? k_d : sel_q;
        latch_d = (state_d == S_LATCH);
        busy_d  = (state_d != S_IDLE);
        ovr_d   = ovr_set | (ovr_q & ~clr_err);
        to_d    = to_set | (to_q & ~clr_err);
    end

    // State, index, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            lsb_q   <= 1'b0;
            lrst_q  <= '0;
            sel_q   <= '0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            lsb_q   <= lsb_d;
            lrst_q  <= lrst_d;
            sel_q   <= sel_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
        end
    end

    assign lsb_shift   = lsb_q;
    assign layer_rst   = lrst_q;
    assign layer_sel   = sel_q;
    assign out_latch   = latch_q;
    assign busy        = busy_q;
    assign overrun     = ovr_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: a pass-level schedule model fills per-cycle
// expectation tables, then the DUT is run and every output checked each cycle.
module tb_layer_sequencer;

    localparam int NL = 2;
    localparam int TO = 15;
    localparam int SW = 1;
    localparam int NC = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_clk;
    logic [NL-1:0] layer_done;
    logic          clr_err;
    logic          lsb_shift;
    logic [NL-1:0] layer_rst;
    logic [SW-1:0] layer_sel;
    logic          out_latch;
    logic          busy;
    logic          overrun;
    logic          timeout_err;

    always #5 clk = ~clk;

    layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_clk  (sample_clk),
        .layer_done  (layer_done),
        .clr_err     (clr_err),
        .lsb_shift   (lsb_shift),
        .layer_rst   (layer_rst),
        .layer_sel   (layer_sel),
        .out_latch   (out_latch),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    // stimulus tables (value driven during cycle c)
    logic          samp_a [NC];
    logic          rst_a  [NC];
    logic          clr_a  [NC];
    logic [NL-1:0] done_a [NC];

    // expectation tables (value seen during cycle c)
    logic          e_lsb   [NC];
    logic [NL-1:0] e_rst   [NC];
    logic          e_latch [NC];
    logic          e_busy  [NC];
    logic          e_ovr   [NC];
    logic          e_to    [NC];
    int            e_sel   [NC];
    logic          sel_def [NC];
    logic          ovr_set [NC];
    logic          to_set  [NC];

    int pd [NL];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic clear_after(input int t);
        for (int c = t + 1; c < NC; c++) begin
            e_lsb[c]   = 1'b0;
            e_rst[c]   = '0;
            e_latch[c] = 1'b0;
            e_busy[c]  = 1'b0;
            sel_def[c] = 1'b0;
        end
        for (int c = t; c < NC; c++) to_set[c] = 1'b0;
    endtask

    task automatic mark_run(input int c, input int k);
        e_busy[c]  = 1'b1;
        e_sel[c]   = k;
        sel_def[c] = 1'b1;
    endtask

    // One pass whose tick lands in cycle t, using layer durations pd[].
    task automatic plan_tick(input int t);
        int h;
        int s;
        h = $urandom_range(1, 2);
        for (int i = 0; i < h; i++) samp_a[t - 3 + i] = 1'b1;
        if (e_busy[t]) ovr_set[t] = 1'b1;
        clear_after(t);
        e_lsb[t + 1]  = 1'b1;
        e_busy[t + 1] = 1'b1;
        s = t + 2;
        for (int k = 0; k < NL; k++) begin
            e_rst[s] = NL'(1) << k;
            mark_run(s, k);
            mark_run(s + 1, k);
            if (pd[k] > TO + 1) begin
                for (int j = 1; j <= TO + 1; j++) begin
                    mark_run(s + 1 + j, k);
                    done_a[s + 1 + j][k] = 1'b0;
                end
                to_set[s + TO + 2] = 1'b1;
                return;
            end
            for (int j = 1; j <= pd[k]; j++) begin
                mark_run(s + 1 + j, k);
                done_a[s + 1 + j][k] = (j == pd[k]);
            end
            s = s + 2 + pd[k];
        end
        e_latch[s] = 1'b1;
        e_busy[s]  = 1'b1;
    endtask

    task automatic plan_reset(input int r);
        rst_a[r] = 1'b1;
        clear_after(r);
        e_sel[r + 1]   = 0;
        sel_def[r + 1] = 1'b1;
    endtask

    task automatic set_d(input int d0, input int d1);
        pd[0] = d0;
        pd[1] = d1;
    endtask

    initial begin
        int t;
        int total;
        bit tout;

        for (int c = 0; c < NC; c++) begin
            samp_a[c]  = 1'b0;
            rst_a[c]   = 1'b0;
            clr_a[c]   = 1'b0;
            done_a[c]  = NL'($urandom);
            e_lsb[c]   = 1'b0;
            e_rst[c]   = '0;
            e_latch[c] = 1'b0;
            e_busy[c]  = 1'b0;
            e_ovr[c]   = 1'b0;
            e_to[c]    = 1'b0;
            e_sel[c]   = 0;
            sel_def[c] = 1'b0;
            ovr_set[c] = 1'b0;
            to_set[c]  = 1'b0;
        end
        for (int c = 0; c < 4; c++) rst_a[c] = 1'b1;

        // basic pass: layers take 3 and 5 cycles
        set_d(3, 5);   plan_tick(20);
        // stale done held on layer 0 through START and first RUN cycle
        set_d(1, 2);   plan_tick(60);
        for (int c = 60; c <= 63; c++) done_a[c][0] = 1'b1;
        // overrun during RUN of layer 1, then a full pass
        set_d(4, 10);  plan_tick(100);
        set_d(2, 3);   plan_tick(112);
        // timeout on layer 1, then a pass at the boundary, then a normal one
        set_d(2, 20);  plan_tick(160);
        set_d(16, 1);  plan_tick(190);
        set_d(3, 3);   plan_tick(220);
        // clear both flags, then clear coinciding with a new overrun
        clr_a[250] = 1'b1;
        set_d(5, 5);   plan_tick(270);
        set_d(2, 2);   plan_tick(275);
        clr_a[275] = 1'b1;
        // reset during RUN of layer 0, then a fresh pass
        set_d(4, 4);   plan_tick(330);
        plan_reset(335);
        set_d(3, 2);   plan_tick(360);
        // tick coincides with last-layer completion
        set_d(3, 4);   plan_tick(400);
        set_d(2, 2);   plan_tick(412);

        // randomized passes, overruns, timeouts and error clears
        for (int c = 450; c < NC; c++) clr_a[c] = ($urandom_range(0, 15) == 0);
        t = 450;
        while (1) begin
            for (int k = 0; k < NL; k++)
                pd[k] = ($urandom_range(0, 7) == 0) ? TO + 2 : $urandom_range(1, 6);
            total = 2;
            tout  = 1'b0;
            for (int k = 0; k < NL; k++) begin
                if (!tout) begin
                    if (pd[k] > TO + 1) begin
                        total += TO + 3;
                        tout = 1'b1;
                    end else begin
                        total += 2 + pd[k];
                    end
                end
            end
            if (t + total + 30 >= NC) break;
            plan_tick(t);
            if ($urandom_range(0, 3) == 0) t = t + $urandom_range(4, total);
            else                           t = t + total + $urandom_range(2, 15);
        end

        // layer_sel holds between passes; sticky flags follow set/clear/reset
        for (int c = 1; c < NC; c++) begin
            if (!sel_def[c]) e_sel[c] = e_sel[c - 1];
            e_ovr[c] = rst_a[c - 1] ? 1'b0 : (ovr_set[c - 1] | (e_ovr[c - 1] & ~clr_a[c - 1]));
            e_to[c]  = rst_a[c - 1] ? 1'b0 : (to_set[c - 1]  | (e_to[c - 1]  & ~clr_a[c - 1]));
        end

        rst        = rst_a[0];
        sample_clk = samp_a[0];
        clr_err    = clr_a[0];
        layer_done = done_a[0];
        for (int c = 1; c < NC; c++) begin
            @(posedge clk);
            #1;
            chk_eq($sformatf("lsb_shift@%0d", c),   int'(lsb_shift),   int'(e_lsb[c]));
            chk_eq($sformatf("layer_rst@%0d", c),   int'(layer_rst),   int'(e_rst[c]));
            chk_eq($sformatf("layer_sel@%0d", c),   int'(layer_sel),   e_sel[c]);
            chk_eq($sformatf("out_latch@%0d", c),   int'(out_latch),   int'(e_latch[c]));
            chk_eq($sformatf("busy@%0d", c),        int'(busy),        int'(e_busy[c]));
            chk_eq($sformatf("overrun@%0d", c),     int'(overrun),     int'(e_ovr[c]));
            chk_eq($sformatf("timeout_err@%0d", c), int'(timeout_err), int'(e_to[c]));
            rst        = rst_a[c];
            sample_clk = samp_a[c];
            clr_err    = clr_a[c];
            layer_done = done_a[c];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
